evaluate_network_ctrl: RTL and testbench
========================================

Name: evaluate_network_ctrl

Overview:
Sequencer for the evaluate_network sliding-window datapath. It accepts a stream of BITS-wide samples, assembles a KERNEL-sample stride-1 window and presents it on net_data. It tracks the network's fixed pipeline latency so each result is tagged. Results are captured into a small output FIFO with valid/ready, and input is throttled by a credit scheme because evaluate_network itself has no stall.

Parameters:
BITS, 16, sample width.
KERNEL, 7, window length in samples.
OVERHEAD_BITS, 12, accumulator growth bits; result width RW = 2*BITS+OVERHEAD_BITS (44).
NET_LATENCY, 2, cycles from net_data change to matching net_result (>=1).
FIFO_DEPTH, 4, result FIFO entries (power of 2).
LEN_BITS, 16, width of frame length field.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle frame start pulse
cfg_len  in  LEN_BITS  samples in frame, sampled on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at frame completion
err  out  1  one-cycle pulse, frame rejected (cfg_len < KERNEL)
in_data  in  BITS  input sample
in_valid  in  1  sample valid
in_ready  out  1  sample accepted when in_valid&&in_ready
net_data  out  BITS*KERNEL  window to evaluate_network; oldest sample in MSBs, newest in [BITS-1:0]
net_result  in  RW  result from evaluate_network
res_data  out  RW  result FIFO head
res_valid  out  1  FIFO non-empty
res_ready  in  1  consumer pop
res_last  out  1  head is final window of frame

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, net_data 0, FIFO empty, counters/tags cleared. Reset mid-frame abandons the frame; no done pulse follows.
- States: IDLE, FILL, RUN, DRAIN.
- IDLE: in_ready=0. start=1 latches cfg_len and enters FILL with busy=1 next cycle. If cfg_len<KERNEL: err and done pulse together next cycle, stay IDLE, busy stays 0.
- start while busy is ignored.
- FILL: in_ready=1. Each accepted sample shifts into the window (window <= {window[lower], in_data}). Enter RUN after KERNEL-1 accepts. No results are issued.
- RUN: in_ready = (fifo_count + inflight < FIFO_DEPTH). Each accept shifts the window and sets tag[0]=1 on the same edge, so net_data for that window is visible from the next cycle.
  - When total accepts reach cfg_len, mark that tag as last and go to DRAIN.
  - Cycles without an accept present a held window with tag 0, and the corresponding net_result is discarded.
- Tag pipeline: NET_LATENCY-deep shift of {valid,last}. The window presented in cycle c yields net_result sampled at the end of cycle c+NET_LATENCY-1 (tag exit). On tag exit with valid=1, push {net_result,last} into the FIFO. inflight = popcount of valid tags.
  - The credit rule guarantees the FIFO never overflows; push and pop in the same cycle are both allowed.
- FIFO: registered-output FWFT. res_valid=1 when non-empty; pop on res_valid&&res_ready. res_last accompanies the head entry.
- DRAIN: in_ready=0. When the entry with last=1 pops, done pulses the next cycle, busy drops with done, and the state returns to IDLE.
- Windows per frame = cfg_len-KERNEL+1. Results emerge in issue order.
- Arithmetic: sample counter LEN_BITS wide, no wrap within a frame; the block does no data arithmetic.

Test Plan:
- Reset, BITS=16, KERNEL=7, NET_LATENCY=2: cfg_len=9, samples 1..9 back-to-back, res_ready=1.
  - First issued net_data = 112'h0001_0002_0003_0004_0005_0006_0007, then ..._0008, then ..._0009.
  - 3 results appear in order; res_last only on the third; done pulses 1 cycle after its pop; busy falls with done.
- Backpressure: FIFO_DEPTH=4, cfg_len=20, res_ready=0, in_valid=1 held.
  - Exactly 10 samples accepted (6 FILL + 4 RUN), then in_ready=0 and res_valid=1 with 4 entries.
  - Raising res_ready for 1 cycle lets exactly 1 more sample be accepted once credit returns.
- Bubbles: cfg_len=8 with in_valid toggling 1/0 → exactly 2 FIFO pushes; held windows during gaps produce no push.
- Short frame: start with cfg_len=5 → err=1 and done=1 in the same single cycle, in_ready never asserted, busy stays 0.
- Reset mid-RUN: assert rst_n=0 with 2 results in flight → all outputs 0 immediately; after release, no done pulse and no res_valid. A new start with cfg_len=7 yields exactly one result with res_last=1.
- start pulse during RUN with a different cfg_len → ignored; the frame completes with the original window count.

Source files
------------

// File: rtl/evaluate_network_ctrl.sv
// Sequencer for the evaluate_network sliding-window datapath: assembles the
// sample window, tags each issued window through the network latency, collects
// tagged results in a small FWFT FIFO and throttles input by FIFO credit.
module evaluate_network_ctrl #(
  parameter int unsigned BITS          = 16,
  parameter int unsigned KERNEL        = 7,
  parameter int unsigned OVERHEAD_BITS = 12,
  parameter int unsigned NET_LATENCY   = 2,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned LEN_BITS      = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [LEN_BITS-1:0]             cfg_len,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  input  logic [BITS-1:0]                 in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [BITS*KERNEL-1:0]          net_data,
  input  logic [2*BITS+OVERHEAD_BITS-1:0] net_result,
  output logic [2*BITS+OVERHEAD_BITS-1:0] res_data,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic                            res_last
);

  localparam int unsigned RW = 2*BITS + OVERHEAD_BITS;
  localparam int unsigned WW = BITS*KERNEL;
  localparam int unsigned EW = RW + 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = $clog2(FIFO_DEPTH + NET_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [LEN_BITS-1:0]    len_q, len_d;
  logic [LEN_BITS-1:0]    cnt_q, cnt_d;
  logic [WW-1:0]          window_q, window_d;
  logic [NET_LATENCY-1:0] tag_v_q, tag_v_d;
  logic [NET_LATENCY-1:0] tag_l_q, tag_l_d;
  logic [SW-1:0]          inflight_d;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          fcnt_q, fcnt_d;
  logic [EW-1:0]          head_q, head_d;
  logic                   res_valid_q, res_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   in_ready_q, in_ready_d;

  logic                   accept, issue, last_issue, fill_done, short_len;
  logic                   push, pop, head_last;
  logic [EW-1:0]          push_entry;

  assign accept     = in_valid && in_ready_q;
  assign issue      = accept && (state_q == S_RUN);
  assign last_issue = issue && ((cnt_q + LEN_BITS'(1)) == len_q);
  assign fill_done  = accept && (cnt_q == LEN_BITS'(KERNEL - 2));
  assign short_len  = cfg_len < LEN_BITS'(KERNEL);
  assign push       = tag_v_q[NET_LATENCY-1];
  assign pop        = res_valid_q && res_ready;
  assign head_last  = head_q[RW];
  assign push_entry = {tag_l_q[NET_LATENCY-1], net_result};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && !short_len) state_d = S_FILL;
      S_FILL:  if (fill_done)           state_d = S_RUN;
      S_RUN:   if (last_issue)          state_d = S_DRAIN;
      S_DRAIN: if (pop && head_last)    state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  // Next values of window, tags, FIFO and registered outputs
  always_comb begin
    len_d      = len_q;
    cnt_d      = cnt_q;
    window_d   = window_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    tag_v_d    = '0;
    tag_l_d    = '0;
    inflight_d = '0;

    if ((state_q == S_IDLE) && start) begin
      len_d = cfg_len;
      cnt_d = '0;
      if (short_len) begin
        err_d  = 1'b1;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end

    if (accept) begin
      cnt_d    = cnt_q + LEN_BITS'(1);
      window_d = {window_q[WW-BITS-1:0], in_data};
    end

    if ((state_q == S_DRAIN) && pop && head_last) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end

    // Tags ride alongside the window through the network latency
    tag_v_d[0] = issue;
    tag_l_d[0] = last_issue;
    for (int i = 1; i < int'(NET_LATENCY); i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_l_d[i] = tag_l_q[i-1];
    end
    for (int i = 0; i < int'(NET_LATENCY); i++) begin
      inflight_d = inflight_d + SW'(tag_v_d[i]);
    end

    wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (push && !pop)      fcnt_d = fcnt_q + CW'(1);
    else if (!push && pop) fcnt_d = fcnt_q - CW'(1);

    // Head register bypasses the array when the new head is being written
    head_d = '0;
    if (fcnt_d != '0) begin
      head_d = (push && (wr_ptr_q == rd_ptr_d)) ? push_entry : mem_q[rd_ptr_d];
    end
    res_valid_d = (fcnt_d != '0);

    in_ready_d = (state_d == S_FILL) ||
                 ((state_d == S_RUN) && ((SW'(fcnt_d) + inflight_d) < SW'(FIFO_DEPTH)));
  end

  // Control and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      cnt_q       <= '0;
      window_q    <= '0;
      tag_v_q     <= '0;
      tag_l_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcnt_q      <= '0;
      head_q      <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      window_q    <= window_d;
      tag_v_q     <= tag_v_d;
      tag_l_q     <= tag_l_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcnt_q      <= fcnt_d;
      head_q      <= head_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // FIFO storage; entries are only read after being written
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign in_ready  = in_ready_q;
  assign net_data  = window_q;
  assign res_data  = head_q[RW-1:0];
  assign res_last  = head_q[RW];
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_evaluate_network_ctrl.sv
// Directed bench for evaluate_network_ctrl with a one-register network stub.
module tb_evaluate_network_ctrl;

  localparam int unsigned BITS          = 16;
  localparam int unsigned KERNEL        = 7;
  localparam int unsigned OVERHEAD_BITS = 12;
  localparam int unsigned NET_LATENCY   = 2;
  localparam int unsigned FIFO_DEPTH    = 4;
  localparam int unsigned LEN_BITS      = 16;
  localparam int unsigned RW            = 2*BITS + OVERHEAD_BITS;
  localparam int unsigned WW            = BITS*KERNEL;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [LEN_BITS-1:0] cfg_len = '0;
  logic                busy, done, err;
  logic [BITS-1:0]     in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [WW-1:0]       net_data;
  logic [RW-1:0]       net_result;
  logic [RW-1:0]       res_data;
  logic                res_valid;
  logic                res_ready = 1'b0;
  logic                res_last;

  evaluate_network_ctrl #(
    .BITS(BITS), .KERNEL(KERNEL), .OVERHEAD_BITS(OVERHEAD_BITS),
    .NET_LATENCY(NET_LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .LEN_BITS(LEN_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .busy(busy), .done(done), .err(err),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .net_data(net_data), .net_result(net_result),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_last(res_last)
  );

  always #5 clk = ~clk;

  // Network stub: result is the newest two samples, one cycle after the window
  always @(posedge clk) net_result <= RW'(net_data[31:0]);

  int n_chk = 0;
  int n_pass = 0;

  // Handshake monitor, sampled mid-cycle
  int acc_cnt = 0, pop_cnt = 0, last_cnt = 0, done_cnt = 0, err_cnt = 0;
  int ready_cnt = 0, valid_cnt = 0, cyc = 0;
  int last_pop_cyc = 0, done_cyc = 0, last_idx = 0;
  logic busy_at_done = 1'b0, busy_at_lastpop = 1'b0;
  logic [RW-1:0] got_q[$];

  always @(negedge clk) begin
    cyc++;
    if (in_valid && in_ready) acc_cnt++;
    if (in_ready) ready_cnt++;
    if (res_valid) valid_cnt++;
    if (res_valid && res_ready) begin
      if (res_last) begin
        last_cnt++;
        last_pop_cyc    = cyc;
        busy_at_lastpop = busy;
        last_idx        = got_q.size();
      end
      pop_cnt++;
      got_q.push_back(res_data);
    end
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    if (err) err_cnt++;
  end

  int k_next = 1;
  int done_base = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int len);
    start   = 1'b1;
    cfg_len = LEN_BITS'(len);
    step();
    start     = 1'b0;
    k_next    = 1;
    done_base = done_cnt;
  endtask

  // Feed samples k_next..len, optionally every other cycle, optionally until done
  task automatic stream(input int n, input int len, input bit gap, input bit until_done);
    bit adv;
    for (int c = 0; (c < n) && !(until_done && (done_cnt != done_base)); c++) begin
      in_valid = (k_next <= len) && (!gap || ((c % 2) == 0));
      in_data  = BITS'(k_next);
      adv      = in_valid && in_ready;
      step();
      if (adv) k_next++;
    end
    if (until_done) check_eq("done_seen", 128'(done_cnt - done_base), 128'(1));
  endtask

  initial begin
    int ab, pb, lb, gb, eb, rb, db, vb;

    // Reset state
    step();
    step();
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_in_ready", 128'(in_ready), 128'(0));
    check_eq("rst_res_valid", 128'(res_valid), 128'(0));
    check_eq("rst_net_data", 128'(net_data), 128'(0));
    check_eq("rst_done_err", 128'({done, err}), 128'(0));
    rst_n = 1'b1;
    step();

    // Basic frame: 9 samples, 3 windows
    res_ready = 1'b1;
    pb = pop_cnt; lb = last_cnt; gb = got_q.size(); eb = err_cnt;
    start_frame(9);
    check_eq("t1_busy", 128'(busy), 128'(1));
    check_eq("t1_ready_fill", 128'(in_ready), 128'(1));
    for (int i = 1; i <= 9; i++) begin
      in_valid = 1'b1;
      in_data  = BITS'(i);
      step();
      if (i == 7) check_eq("t1_win7", 128'(net_data), 128'(112'h0001_0002_0003_0004_0005_0006_0007));
      if (i == 8) check_eq("t1_win8", 128'(net_data), 128'(112'h0002_0003_0004_0005_0006_0007_0008));
      if (i == 9) check_eq("t1_win9", 128'(net_data), 128'(112'h0003_0004_0005_0006_0007_0008_0009));
    end
    in_valid = 1'b0;
    k_next = 10;
    stream(40, 0, 1'b0, 1'b1);
    check_eq("t1_pops", 128'(pop_cnt - pb), 128'(3));
    check_eq("t1_res0", 128'(got_q[gb]), 128'(44'h000_0006_0007));
    check_eq("t1_res1", 128'(got_q[gb+1]), 128'(44'h000_0007_0008));
    check_eq("t1_res2", 128'(got_q[gb+2]), 128'(44'h000_0008_0009));
    check_eq("t1_last_cnt", 128'(last_cnt - lb), 128'(1));
    check_eq("t1_last_idx", 128'(last_idx - gb), 128'(2));
    check_eq("t1_done_lag", 128'(done_cyc - last_pop_cyc), 128'(1));
    check_eq("t1_busy_lastpop", 128'(busy_at_lastpop), 128'(1));
    check_eq("t1_busy_at_done", 128'(busy_at_done), 128'(0));
    check_eq("t1_no_err", 128'(err_cnt - eb), 128'(0));

    // Backpressure: credit limits accepts to FIFO_DEPTH windows
    res_ready = 1'b0;
    ab = acc_cnt; pb = pop_cnt; lb = last_cnt;
    start_frame(20);
    stream(30, 20, 1'b0, 1'b0);
    check_eq("t2_acc10", 128'(acc_cnt - ab), 128'(10));
    check_eq("t2_ready_low", 128'(in_ready), 128'(0));
    check_eq("t2_res_valid", 128'(res_valid), 128'(1));
    check_eq("t2_head", 128'(res_data), 128'(44'h000_0006_0007));
    check_eq("t2_no_pop", 128'(pop_cnt - pb), 128'(0));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    stream(10, 20, 1'b0, 1'b0);
    check_eq("t2_acc11", 128'(acc_cnt - ab), 128'(11));
    check_eq("t2_one_pop", 128'(pop_cnt - pb), 128'(1));
    check_eq("t2_ready_low2", 128'(in_ready), 128'(0));
    res_ready = 1'b1;
    stream(300, 20, 1'b0, 1'b1);
    in_valid = 1'b0;
    check_eq("t2_acc20", 128'(acc_cnt - ab), 128'(20));
    check_eq("t2_pops", 128'(pop_cnt - pb), 128'(14));
    check_eq("t2_last_cnt", 128'(last_cnt - lb), 128'(1));
    check_eq("t2_last_res", 128'(got_q[last_idx]), 128'(44'h000_0013_0014));
    check_eq("t2_busy_end", 128'(busy), 128'(0));

    // Bubbles: held windows during gaps produce no result
    pb = pop_cnt; gb = got_q.size(); ab = acc_cnt;
    start_frame(8);
    stream(100, 8, 1'b1, 1'b1);
    in_valid = 1'b0;
    check_eq("t3_acc", 128'(acc_cnt - ab), 128'(8));
    check_eq("t3_pops", 128'(pop_cnt - pb), 128'(2));
    check_eq("t3_res0", 128'(got_q[gb]), 128'(44'h000_0006_0007));
    check_eq("t3_res1", 128'(got_q[gb+1]), 128'(44'h000_0007_0008));
    check_eq("t3_empty", 128'(res_valid), 128'(0));

    // Short frame is rejected
    eb = err_cnt; rb = ready_cnt; db = done_cnt;
    start   = 1'b1;
    cfg_len = LEN_BITS'(5);
    step();
    start = 1'b0;
    check_eq("t4_err", 128'(err), 128'(1));
    check_eq("t4_done", 128'(done), 128'(1));
    check_eq("t4_busy", 128'(busy), 128'(0));
    step();
    check_eq("t4_pulse_end", 128'({err, done}), 128'(0));
    for (int i = 0; i < 5; i++) step();
    check_eq("t4_err_cnt", 128'(err_cnt - eb), 128'(1));
    check_eq("t4_done_cnt", 128'(done_cnt - db), 128'(1));
    check_eq("t4_no_ready", 128'(ready_cnt - rb), 128'(0));

    // Reset mid-RUN with two windows in flight
    res_ready = 1'b0;
    start_frame(20);
    stream(8, 20, 1'b0, 1'b0);
    check_eq("t5_busy_pre", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_ctrl", 128'({busy, done, err, in_ready}), 128'(0));
    check_eq("t5_rst_res", 128'({res_valid, res_last}), 128'(0));
    check_eq("t5_rst_data", 128'(res_data), 128'(0));
    check_eq("t5_rst_win", 128'(net_data), 128'(0));
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    db = done_cnt; vb = valid_cnt;
    for (int i = 0; i < 10; i++) step();
    check_eq("t5_no_done", 128'(done_cnt - db), 128'(0));
    check_eq("t5_no_valid", 128'(valid_cnt - vb), 128'(0));
    res_ready = 1'b1;
    pb = pop_cnt; lb = last_cnt;
    start_frame(7);
    stream(60, 7, 1'b0, 1'b1);
    in_valid = 1'b0;
    check_eq("t5_pops", 128'(pop_cnt - pb), 128'(1));
    check_eq("t5_last", 128'(last_cnt - lb), 128'(1));
    check_eq("t5_res", 128'(got_q[last_idx]), 128'(44'h000_0006_0007));

    // start during RUN is ignored
    pb = pop_cnt; lb = last_cnt; ab = acc_cnt; eb = err_cnt;
    start_frame(10);
    stream(8, 10, 1'b0, 1'b0);
    start   = 1'b1;
    cfg_len = LEN_BITS'(7);
    stream(1, 10, 1'b0, 1'b0);
    start   = 1'b0;
    cfg_len = LEN_BITS'(10);
    stream(100, 10, 1'b0, 1'b1);
    in_valid = 1'b0;
    check_eq("t6_acc", 128'(acc_cnt - ab), 128'(10));
    check_eq("t6_pops", 128'(pop_cnt - pb), 128'(4));
    check_eq("t6_last", 128'(last_cnt - lb), 128'(1));
    check_eq("t6_last_res", 128'(got_q[last_idx]), 128'(44'h000_0009_000A));
    check_eq("t6_no_err", 128'(err_cnt - eb), 128'(0));
    step();
    check_eq("t6_busy_end", 128'(busy), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
